// File: rtl/zrb_uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : zrb_uart_pkg
//  Description : Shared UART definitions: receiver/transmitter state encoding,
//                default oversampling ratio and tick counter width.
//  Revision    : 1.0  initial release
// ============================================================================
package zrb_uart_pkg;

    // baud_tick pulses per UART bit when the instantiating module does not override it
    localparam int unsigned c_OVERSAMPLE_DEFAULT = 16;

    // Tick counter width; wide enough for the largest legal OVERSAMPLE (64)
    localparam int unsigned c_TICK_W = 6;

    // Frame state encoding; PARITY is only visited when parity checking is built in
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } uart_state_e;

endpackage
`default_nettype wire

// File: rtl/zrb_sync2.sv
`default_nettype none
// ============================================================================
//  Module      : zrb_sync2
//  Description : Parameterized-width two-flop synchronizer. Both stages reset
//                to all-ones so an idle-high line never looks active at reset.
//  Revision    : 1.0  initial release
// ============================================================================
module zrb_sync2 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // Two back-to-back flops give the first stage a full cycle to settle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '1;
            r_sync <= '1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/zrb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : zrb_uart_rx
//  Description : Oversampling UART receiver, 8N1. Start bit is qualified at
//                mid-bit, data and stop bits are sampled one bit period apart.
//                Define ZRB_UART_RX_PARITY_EN for 8E1 with a parity_error output.
//  Revision    : 1.0  initial release
// ============================================================================
module zrb_uart_rx
    import zrb_uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = c_OVERSAMPLE_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       baud_tick,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_error,
    output logic       busy
`ifdef ZRB_UART_RX_PARITY_EN
    ,
    output logic       parity_error
`endif
);

    // Tick count at which the start bit is re-checked (middle of the bit)
    localparam logic [c_TICK_W-1:0] c_HALF = c_TICK_W'(OVERSAMPLE/2 - 1);
    // Tick count at which each following bit is sampled (one bit period later)
    localparam logic [c_TICK_W-1:0] c_FULL = c_TICK_W'(OVERSAMPLE - 1);

    logic                w_rx;
    uart_state_e         r_state, w_state_nxt;
    logic [c_TICK_W-1:0] r_tick_cnt, w_tick_nxt;
    logic [2:0]          r_bit_cnt, w_bit_nxt;
    logic [7:0]          r_shift, w_shift_nxt;
    logic [7:0]          r_data, w_data_nxt;
    logic                r_valid, w_valid_nxt;
    logic                r_ferr, w_ferr_nxt;
`ifdef ZRB_UART_RX_PARITY_EN
    logic                r_par_bad, w_par_bad_nxt;
    logic                r_perr, w_perr_nxt;
`endif

    zrb_sync2 #(
        .WIDTH (1)
    ) u_sync_rx (
        .clk   (clk),
        .rst_n (reset),
        .i_d   (rx),
        .o_q   (w_rx)
    );

    // Next-state and datapath decode; counters only move on baud_tick
    always_comb begin
        w_state_nxt = r_state;
        w_tick_nxt  = r_tick_cnt;
        w_bit_nxt   = r_bit_cnt;
        w_shift_nxt = r_shift;
        w_data_nxt  = r_data;
        w_valid_nxt = 1'b0;
        w_ferr_nxt  = 1'b0;
`ifdef ZRB_UART_RX_PARITY_EN
        w_par_bad_nxt = r_par_bad;
        w_perr_nxt    = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (!w_rx) begin
                    w_state_nxt = ST_START;
                    w_tick_nxt  = '0;
                end
            end
            ST_START: begin
                if (baud_tick) begin
                    if (r_tick_cnt == c_HALF) begin
                        w_tick_nxt  = '0;
                        w_bit_nxt   = 3'd0;
                        // A line already back high at mid-bit was a glitch
                        w_state_nxt = w_rx ? ST_IDLE : ST_DATA;
                    end else begin
                        w_tick_nxt = r_tick_cnt + c_TICK_W'(1);
                    end
                end
            end
            ST_DATA: begin
                if (baud_tick) begin
                    if (r_tick_cnt == c_FULL) begin
                        w_tick_nxt             = '0;
                        w_shift_nxt[r_bit_cnt] = w_rx;
                        w_bit_nxt              = r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
`ifdef ZRB_UART_RX_PARITY_EN
                            w_state_nxt = ST_PARITY;
`else
                            w_state_nxt = ST_STOP;
`endif
                        end
                    end else begin
                        w_tick_nxt = r_tick_cnt + c_TICK_W'(1);
                    end
                end
            end
`ifdef ZRB_UART_RX_PARITY_EN
            ST_PARITY: begin
                if (baud_tick) begin
                    if (r_tick_cnt == c_FULL) begin
                        w_tick_nxt    = '0;
                        // Even parity: data plus parity bit must hold an even number of ones
                        w_par_bad_nxt = ^{r_shift, w_rx};
                        w_state_nxt   = ST_STOP;
                    end else begin
                        w_tick_nxt = r_tick_cnt + c_TICK_W'(1);
                    end
                end
            end
`endif
            ST_STOP: begin
                if (baud_tick) begin
                    if (r_tick_cnt == c_FULL) begin
                        w_tick_nxt = '0;
                        if (w_rx) begin
                            w_data_nxt  = r_shift;
                            w_valid_nxt = 1'b1;
`ifdef ZRB_UART_RX_PARITY_EN
                            w_perr_nxt  = r_par_bad;
`endif
                            w_state_nxt = ST_IDLE;
                        end else begin
                            w_ferr_nxt  = 1'b1;
                            w_state_nxt = ST_WAIT_IDLE;
                        end
                    end else begin
                        w_tick_nxt = r_tick_cnt + c_TICK_W'(1);
                    end
                end
            end
            ST_WAIT_IDLE: begin
                // A held-low break must end before a new start edge can be seen
                if (w_rx) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, counters, shift register and output pulse registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_tick_cnt <= '0;
            r_bit_cnt  <= 3'd0;
            r_shift    <= 8'h00;
            r_data     <= 8'h00;
            r_valid    <= 1'b0;
            r_ferr     <= 1'b0;
`ifdef ZRB_UART_RX_PARITY_EN
            r_par_bad  <= 1'b0;
            r_perr     <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_tick_cnt <= w_tick_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_shift    <= w_shift_nxt;
            r_data     <= w_data_nxt;
            r_valid    <= w_valid_nxt;
            r_ferr     <= w_ferr_nxt;
`ifdef ZRB_UART_RX_PARITY_EN
            r_par_bad  <= w_par_bad_nxt;
            r_perr     <= w_perr_nxt;
`endif
        end
    end

    assign data        = r_data;
    assign valid       = r_valid;
    assign frame_error = r_ferr;
    assign busy        = (r_state != ST_IDLE);
`ifdef ZRB_UART_RX_PARITY_EN
    assign parity_error = r_perr;
`endif

endmodule
`default_nettype wire

// File: tb/tb_zrb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_zrb_uart_rx
//  Description : Directed self-checking bench for zrb_uart_rx (OVERSAMPLE=16).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_zrb_uart_rx;

    localparam int OS = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       baud_tick = 1'b1;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       frame_error;
    logic       busy;
`ifdef ZRB_UART_RX_PARITY_EN
    logic       parity_error;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Pulse bookkeeping collected by the monitor
    int         vcnt = 0;
    int         fecnt = 0;
    int         pecnt = 0;
    int         overlap_cnt = 0;
    int         wide_cnt = 0;
    logic [7:0] got_q[$];
    logic       prev_v = 1'b0;
    logic       prev_f = 1'b0;
    logic       slow = 1'b0;

    int v0, f0, p0, q0;

    zrb_uart_rx #(
        .OVERSAMPLE (OS)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .baud_tick    (baud_tick),
        .rx           (rx),
        .data         (data),
        .valid        (valid),
        .frame_error  (frame_error),
        .busy         (busy)
`ifdef ZRB_UART_RX_PARITY_EN
        ,
        .parity_error (parity_error)
`endif
    );

    always #5 clk = ~clk;

    // Tick every clock normally, every other clock in slow mode
    always @(negedge clk) baud_tick = slow ? ~baud_tick : 1'b1;

    always @(negedge clk) begin
        if (valid) begin
            vcnt++;
            got_q.push_back(data);
        end
        if (frame_error) fecnt++;
        if (valid && frame_error) overlap_cnt++;
        if ((valid && prev_v) || (frame_error && prev_f)) wide_cnt++;
`ifdef ZRB_UART_RX_PARITY_EN
        if (parity_error) pecnt++;
        if (parity_error && !valid) overlap_cnt++;
`endif
        prev_v = valid;
        prev_f = frame_error;
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        clks(OS * (slow ? 2 : 1));
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef ZRB_UART_RX_PARITY_EN
        send_bit(par);
`else
        if (par === 1'bz) rx = 1'b1;
`endif
        send_bit(stop);
    endtask

    task automatic snap();
        v0 = vcnt;
        f0 = fecnt;
        p0 = pecnt;
        q0 = got_q.size();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rx    = 1'b1;
        reset = 1'b0;
        clks(3);
        check_eq("rst_data", 32'(data), 32'h00);
        check_eq("rst_valid", 32'(valid), 32'h0);
        check_eq("rst_ferr", 32'(frame_error), 32'h0);
        check_eq("rst_busy", 32'(busy), 32'h0);
        reset = 1'b1;
        clks(4);
        check_eq("idle_busy", 32'(busy), 32'h0);

        // Single good frame
        snap();
        send_frame(8'hA5, 1'b1, ^8'hA5);
        clks(2 * OS);
        check_eq("a5_count", 32'(vcnt - v0), 32'd1);
        check_eq("a5_data", 32'(data), 32'hA5);
        check_eq("a5_busy", 32'(busy), 32'h0);

        // Short low glitch is rejected
        snap();
        rx = 1'b0;
        clks(5);
        rx = 1'b1;
        clks(3 * OS);
        check_eq("glitch_valid", 32'(vcnt - v0), 32'd0);
        check_eq("glitch_ferr", 32'(fecnt - f0), 32'd0);
        check_eq("glitch_data", 32'(data), 32'hA5);
        check_eq("glitch_busy", 32'(busy), 32'h0);

        // Bad stop bit followed by a held-low line
        snap();
        send_frame(8'h3C, 1'b0, ^8'h3C);
        rx = 1'b0;
        clks(40);
        check_eq("brk_ferr", 32'(fecnt - f0), 32'd1);
        check_eq("brk_valid", 32'(vcnt - v0), 32'd0);
        check_eq("brk_data", 32'(data), 32'hA5);
        check_eq("brk_busy", 32'(busy), 32'h1);
        rx = 1'b1;
        clks(4);
        check_eq("brk_release", 32'(busy), 32'h0);
        send_frame(8'h01, 1'b1, ^8'h01);
        clks(2 * OS);
        check_eq("after_brk_cnt", 32'(vcnt - v0), 32'd1);
        check_eq("after_brk_data", 32'(data), 32'h01);
        check_eq("after_brk_ferr", 32'(fecnt - f0), 32'd1);

        // Back-to-back frames, no idle gap
        snap();
        send_frame(8'h00, 1'b1, ^8'h00);
        send_frame(8'hFF, 1'b1, ^8'hFF);
        send_frame(8'h55, 1'b1, ^8'h55);
        clks(2 * OS);
        check_eq("b2b_count", 32'(vcnt - v0), 32'd3);
        if (got_q.size() >= q0 + 3) begin
            check_eq("b2b_0", 32'(got_q[q0]), 32'h00);
            check_eq("b2b_1", 32'(got_q[q0 + 1]), 32'hFF);
            check_eq("b2b_2", 32'(got_q[q0 + 2]), 32'h55);
        end else begin
            check_eq("b2b_queue", 32'(got_q.size() - q0), 32'd3);
        end

        // Reset in the middle of data bit 4 of 8'hC3
        snap();
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(((8'hC3 >> i) & 8'h01) != 8'h00);
        rx = 1'b0;
        clks(OS / 2);
        reset = 1'b0;
        clks(3);
        check_eq("midrst_busy", 32'(busy), 32'h0);
        check_eq("midrst_data", 32'(data), 32'h00);
        rx    = 1'b1;
        reset = 1'b1;
        clks(2 * OS);
        send_frame(8'h7E, 1'b1, ^8'h7E);
        clks(2 * OS);
        check_eq("midrst_cnt", 32'(vcnt - v0), 32'd1);
        check_eq("midrst_ferr", 32'(fecnt - f0), 32'd0);
        check_eq("midrst_7e", 32'(data), 32'h7E);

        // Ticks on alternate clocks: counters must only advance on baud_tick
        snap();
        slow = 1'b1;
        clks(4);
        send_frame(8'h96, 1'b1, ^8'h96);
        clks(4 * OS);
        slow = 1'b0;
        clks(4);
        check_eq("slow_cnt", 32'(vcnt - v0), 32'd1);
        check_eq("slow_data", 32'(data), 32'h96);

`ifdef ZRB_UART_RX_PARITY_EN
        // 8'h07 has three ones: even parity bit is 1, so 0 is an error
        snap();
        send_frame(8'h07, 1'b1, 1'b0);
        clks(2 * OS);
        check_eq("par_bad_valid", 32'(vcnt - v0), 32'd1);
        check_eq("par_bad_perr", 32'(pecnt - p0), 32'd1);
        check_eq("par_bad_data", 32'(data), 32'h07);
        snap();
        send_frame(8'h07, 1'b1, 1'b1);
        clks(2 * OS);
        check_eq("par_ok_valid", 32'(vcnt - v0), 32'd1);
        check_eq("par_ok_perr", 32'(pecnt - p0), 32'd0);
`endif

        check_eq("pulse_overlap", 32'(overlap_cnt), 32'd0);
        check_eq("pulse_width", 32'(wide_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
